// File: rtl/denise_sprite_channel.sv
// One Denise sprite channel: POS/CTL/DATA/DATB register block, arm state,
// and the two 16-bit shifters that serialise a sprite line onto sprdata.
module denise_sprite_channel #(
    parameter int SPRNUM = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic [8:1]  reg_address_in,
    input  logic [15:0] data_in,
    input  logic [8:0]  hpos,
    output logic [1:0]  sprdata,
    output logic        nonzero,
    output logic        attach,
    output logic        active
);

    // Channel register block sits at 0x140 + 8*SPRNUM; the bus only carries bits 8:1.
    localparam logic [8:0] POS_ADDR  = 9'h140 + 9'(SPRNUM * 8);
    localparam logic [8:0] CTL_ADDR  = POS_ADDR + 9'd2;
    localparam logic [8:0] DATA_ADDR = POS_ADDR + 9'd4;
    localparam logic [8:0] DATB_ADDR = POS_ADDR + 9'd6;

    typedef enum logic {
        DISARMED,
        ARMED
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [8:0]  r_hstart;
    logic        r_attach;
    logic [15:0] r_datla;
    logic [15:0] r_datlb;
    logic [15:0] r_shifta;
    logic [15:0] r_shiftb;
    logic [3:0]  r_count;
    logic        r_active;

    logic        w_posWr;
    logic        w_ctlWr;
    logic        w_dataWr;
    logic        w_datbWr;
    logic        w_match;

    assign w_posWr  = (reg_address_in == POS_ADDR[8:1]);
    assign w_ctlWr  = (reg_address_in == CTL_ADDR[8:1]);
    assign w_dataWr = (reg_address_in == DATA_ADDR[8:1]);
    assign w_datbWr = (reg_address_in == DATB_ADDR[8:1]);

    // Match uses the registered arm state and hstart, so a write in the same
    // cycle only affects the next line.
    assign w_match = (r_state == ARMED) && (hpos == r_hstart);

    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                r_state <= DISARMED;
            end else begin
                r_state <= w_nextState;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            DISARMED: if (w_dataWr) w_nextState = ARMED;
            ARMED:    if (w_ctlWr)  w_nextState = DISARMED;
            default:  w_nextState = DISARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                r_hstart <= 9'd0;
                r_attach <= 1'b0;
                r_datla  <= 16'd0;
                r_datlb  <= 16'd0;
            end else begin
                if (w_posWr) begin
                    r_hstart[8:1] <= data_in[7:0];
                end
                if (w_ctlWr) begin
                    r_hstart[0] <= data_in[0];
                    r_attach    <= data_in[7];
                end
                if (w_dataWr) begin
                    r_datla <= data_in;
                end
                if (w_datbWr) begin
                    r_datlb <= data_in;
                end
            end
        end
    end

    // A match always wins over shifting, which also gives retrigger for free.
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                r_shifta <= 16'd0;
                r_shiftb <= 16'd0;
                r_count  <= 4'd0;
                r_active <= 1'b0;
            end else if (w_match) begin
                r_shifta <= r_datla;
                r_shiftb <= r_datlb;
                r_count  <= 4'd15;
                r_active <= 1'b1;
            end else begin
                r_shifta <= {r_shifta[14:0], 1'b0};
                r_shiftb <= {r_shiftb[14:0], 1'b0};
                if (r_active) begin
                    if (r_count == 4'd0) begin
                        r_active <= 1'b0;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
            end
        end
    end

    assign sprdata = {r_shiftb[15], r_shifta[15]};
    assign nonzero = |sprdata;
    assign attach  = r_attach;
    assign active  = r_active;

endmodule

// File: tb/tb_denise_sprite_channel.sv
// Scoreboard bench for denise_sprite_channel: channels 0 and 3 share one bus,
// stimulus queues the expected outputs, a monitor pops and compares them.
module tb_denise_sprite_channel;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk7_en;
    logic [7:0]  regAddr;
    logic [15:0] dataIn;
    logic [8:0]  hpos;

    logic [1:0]  spr0, spr3;
    logic        nz0, nz3, att0, att3, act0, act3;

    typedef struct {
        string      name;
        bit         sel3;
        logic [1:0] spr;
        logic       act;
        logic       att;
    } exp_t;

    exp_t expQ[$];
    exp_t curExp;
    int   errors = 0;
    int   checks = 0;
    bit   endReq = 1'b0;
    bit   endDone = 1'b0;

    logic [1:0] gotSpr;
    logic       gotNz, gotAct, gotAtt;

    denise_sprite_channel #(.SPRNUM(0)) dut0 (
        .clk(clk), .reset(reset), .clk7_en(clk7_en),
        .reg_address_in(regAddr), .data_in(dataIn), .hpos(hpos),
        .sprdata(spr0), .nonzero(nz0), .attach(att0), .active(act0)
    );

    denise_sprite_channel #(.SPRNUM(3)) dut3 (
        .clk(clk), .reset(reset), .clk7_en(clk7_en),
        .reg_address_in(regAddr), .data_in(dataIn), .hpos(hpos),
        .sprdata(spr3), .nonzero(nz3), .attach(att3), .active(act3)
    );

    always #5 clk = ~clk;

    // Each step drives at a negedge and queues one record, so exactly one
    // record is due after every rising edge.
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            curExp = expQ.pop_front();
            gotSpr = curExp.sel3 ? spr3 : spr0;
            gotNz  = curExp.sel3 ? nz3  : nz0;
            gotAct = curExp.sel3 ? act3 : act0;
            gotAtt = curExp.sel3 ? att3 : att0;
            checks++;
            if (gotSpr !== curExp.spr || gotNz !== (|curExp.spr) ||
                gotAct !== curExp.act || gotAtt !== curExp.att) begin
                errors++;
                $display("[TB] FAIL %s: got spr=%b nz=%b act=%b att=%b, expected spr=%b nz=%b act=%b att=%b",
                         curExp.name, gotSpr, gotNz, gotAct, gotAtt,
                         curExp.spr, |curExp.spr, curExp.act, curExp.att);
            end
        end
        if (endReq && !endDone) begin
            checks++;
            if (expQ.size() != 0) begin
                errors++;
                $display("[TB] FAIL drain: got %0d pending records, expected 0", expQ.size());
            end
            endDone = 1'b1;
        end
    end

    task automatic applyStimulus(input logic [7:0] a, input logic [15:0] d,
                                 input logic [8:0] h, input logic r, input logic en);
        @(negedge clk);
        regAddr = a;
        dataIn  = d;
        hpos    = h;
        reset   = r;
        clk7_en = en;
    endtask

    task automatic checkOutput(input string n, input bit s3, input logic [1:0] sp,
                               input logic ac, input logic at);
        exp_t e;
        e.name = n;
        e.sel3 = s3;
        e.spr  = sp;
        e.act  = ac;
        e.att  = at;
        expQ.push_back(e);
    endtask

    task automatic doStep(input logic [7:0] a, input logic [15:0] d, input logic [8:0] h,
                          input logic r, input logic en, input string n, input bit s3,
                          input logic [1:0] sp, input logic ac, input logic at);
        applyStimulus(a, d, h, r, en);
        checkOutput(n, s3, sp, ac, at);
    endtask

    // Pixel k of a line is {b[16-k], a[16-k]}; every pixel is followed by an
    // enable-low cycle carrying a DATA write that must be ignored.
    task automatic runLine(input string n, input bit s3, input logic [8:0] startH,
                           input logic [7:0] firstAddr, input logic [15:0] firstData,
                           input logic [15:0] a, input logic [15:0] b, input logic at,
                           input int nPix, input bit finish);
        logic [1:0] px;
        logic [8:0] h;
        for (int i = 0; i < nPix; i++) begin
            px = {b[15-i], a[15-i]};
            h  = startH + 9'(i);
            if (i == 0) applyStimulus(firstAddr, firstData, h, 1'b0, 1'b1);
            else        applyStimulus(8'h00, 16'h0000, h, 1'b0, 1'b1);
            checkOutput($sformatf("%s_px%0d", n, i + 1), s3, px, 1'b1, at);
            doStep(8'hA2, 16'h0000, h, 1'b0, 1'b0, $sformatf("%s_hold%0d", n, i + 1),
                   s3, px, 1'b1, at);
        end
        if (finish) begin
            doStep(8'h00, 16'h0000, startH + 9'(nPix), 1'b0, 1'b1, {n, "_end"},
                   s3, 2'b00, 1'b0, at);
        end
    endtask

    initial begin
        regAddr = 8'h00; dataIn = 16'h0000; hpos = 9'h000; reset = 1'b1; clk7_en = 1'b1;

        doStep(8'h00, 16'h0000, 9'h000, 1'b1, 1'b1, "reset0", 1'b0, 2'b00, 1'b0, 1'b0);
        doStep(8'h00, 16'h0000, 9'h000, 1'b1, 1'b1, "reset3", 1'b1, 2'b00, 1'b0, 1'b0);

        // Basic line at hstart 0x080, then the same arm fires again.
        doStep(8'hA0, 16'h0040, 9'h000, 1'b0, 1'b1, "wrPos",  1'b0, 2'b00, 1'b0, 1'b0);
        doStep(8'hA1, 16'h0000, 9'h000, 1'b0, 1'b1, "wrCtl",  1'b0, 2'b00, 1'b0, 1'b0);
        doStep(8'hA3, 16'h0000, 9'h000, 1'b0, 1'b1, "wrDatb", 1'b0, 2'b00, 1'b0, 1'b0);
        doStep(8'hA2, 16'h8001, 9'h000, 1'b0, 1'b1, "wrData", 1'b0, 2'b00, 1'b0, 1'b0);
        doStep(8'h00, 16'h0000, 9'h07F, 1'b0, 1'b1, "preMatch", 1'b0, 2'b00, 1'b0, 1'b0);
        runLine("line1", 1'b0, 9'h080, 8'h00, 16'h0000, 16'h8001, 16'h0000, 1'b0, 16, 1'b1);
        runLine("rearm", 1'b0, 9'h080, 8'h00, 16'h0000, 16'h8001, 16'h0000, 1'b0, 16, 1'b1);

        // Attach and odd hstart via CTL bit 0.
        doStep(8'hA1, 16'h0081, 9'h000, 1'b0, 1'b0, "ctlEnLow", 1'b0, 2'b00, 1'b0, 1'b0);
        doStep(8'hA1, 16'h0081, 9'h000, 1'b0, 1'b1, "ctlAttach", 1'b0, 2'b00, 1'b0, 1'b1);
        doStep(8'hA2, 16'hFFFF, 9'h000, 1'b0, 1'b1, "attData", 1'b0, 2'b00, 1'b0, 1'b1);
        doStep(8'hA3, 16'hFFFF, 9'h000, 1'b0, 1'b1, "attDatb", 1'b0, 2'b00, 1'b0, 1'b1);
        doStep(8'hA0, 16'h0040, 9'h000, 1'b0, 1'b1, "attPos",  1'b0, 2'b00, 1'b0, 1'b1);
        doStep(8'h00, 16'h0000, 9'h080, 1'b0, 1'b1, "noMatchEven", 1'b0, 2'b00, 1'b0, 1'b1);
        runLine("attached", 1'b0, 9'h081, 8'h00, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1, 16, 1'b1);

        // CTL write before the match disarms the channel.
        doStep(8'hA1, 16'h0081, 9'h000, 1'b0, 1'b1, "disarm",   1'b0, 2'b00, 1'b0, 1'b1);
        doStep(8'h00, 16'h0000, 9'h081, 1'b0, 1'b1, "noLoad",   1'b0, 2'b00, 1'b0, 1'b1);
        doStep(8'h00, 16'h0000, 9'h082, 1'b0, 1'b1, "noLoad2",  1'b0, 2'b00, 1'b0, 1'b1);

        // Retrigger eight pixels into a line.
        doStep(8'hA1, 16'h0000, 9'h000, 1'b0, 1'b1, "rtCtl",  1'b0, 2'b00, 1'b0, 1'b0);
        doStep(8'hA3, 16'h0000, 9'h000, 1'b0, 1'b1, "rtDatb", 1'b0, 2'b00, 1'b0, 1'b0);
        doStep(8'hA2, 16'h8001, 9'h000, 1'b0, 1'b1, "rtData", 1'b0, 2'b00, 1'b0, 1'b0);
        runLine("retrigA", 1'b0, 9'h080, 8'h00, 16'h0000, 16'h8001, 16'h0000, 1'b0, 8, 1'b0);
        runLine("retrigB", 1'b0, 9'h080, 8'h00, 16'h0000, 16'h8001, 16'h0000, 1'b0, 16, 1'b1);

        // DATA write in the match cycle loads the old latch; the new one is used next line.
        doStep(8'hA2, 16'hFFFF, 9'h000, 1'b0, 1'b1, "oldData", 1'b0, 2'b00, 1'b0, 1'b0);
        runLine("sameCycle", 1'b0, 9'h080, 8'hA2, 16'h1234, 16'hFFFF, 16'h0000, 1'b0, 16, 1'b1);
        runLine("nextLoad",  1'b0, 9'h080, 8'h00, 16'h0000, 16'h1234, 16'h0000, 1'b0, 16, 1'b1);

        // Reset mid-line, with a concurrent DATA write that must lose.
        runLine("preReset", 1'b0, 9'h080, 8'h00, 16'h0000, 16'h1234, 16'h0000, 1'b0, 5, 1'b0);
        doStep(8'hA2, 16'hFFFF, 9'h084, 1'b1, 1'b0, "resetEnLow", 1'b0, 2'b00, 1'b1, 1'b0);
        doStep(8'hA2, 16'hFFFF, 9'h085, 1'b1, 1'b1, "resetMid",   1'b0, 2'b00, 1'b0, 1'b0);
        doStep(8'h00, 16'h0000, 9'h000, 1'b0, 1'b1, "postRst0",   1'b0, 2'b00, 1'b0, 1'b0);
        doStep(8'h00, 16'h0000, 9'h080, 1'b0, 1'b1, "postRst80",  1'b0, 2'b00, 1'b0, 1'b0);
        doStep(8'hA2, 16'h8000, 9'h100, 1'b0, 1'b1, "rewrite",    1'b0, 2'b00, 1'b0, 1'b0);
        runLine("afterRearm", 1'b0, 9'h000, 8'h00, 16'h0000, 16'h8000, 16'h0000, 1'b0, 16, 1'b1);

        // Channel 3 ignores channel 0 addresses and decodes 0x158-0x15E.
        doStep(8'hA1, 16'h0081, 9'h100, 1'b0, 1'b1, "c3IgnCtl",  1'b1, 2'b00, 1'b0, 1'b0);
        doStep(8'hA2, 16'hFFFF, 9'h100, 1'b0, 1'b1, "c3IgnData", 1'b1, 2'b00, 1'b0, 1'b0);
        doStep(8'h00, 16'h0000, 9'h000, 1'b0, 1'b1, "c3NoFire",  1'b1, 2'b00, 1'b0, 1'b0);
        doStep(8'hAD, 16'h0080, 9'h100, 1'b0, 1'b1, "c3Ctl",  1'b1, 2'b00, 1'b0, 1'b1);
        doStep(8'hAC, 16'h0010, 9'h100, 1'b0, 1'b1, "c3Pos",  1'b1, 2'b00, 1'b0, 1'b1);
        doStep(8'hAF, 16'hFFFF, 9'h100, 1'b0, 1'b1, "c3Datb", 1'b1, 2'b00, 1'b0, 1'b1);
        doStep(8'hAE, 16'h8000, 9'h100, 1'b0, 1'b1, "c3Data", 1'b1, 2'b00, 1'b0, 1'b1);
        runLine("c3Line", 1'b1, 9'h020, 8'h00, 16'h0000, 16'h8000, 16'hFFFF, 1'b1, 16, 1'b1);

        @(negedge clk);
        endReq = 1'b1;
        for (int k = 0; k < 20 && !endDone; k++) @(posedge clk);
        #2;
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
